// File: rtl/enemy_fire_scheduler.sv
`timescale 1ns/1ps
// enemy_fire_scheduler
// Decides when the 3x3 invader formation returns fire, picks the shooter
// round-robin among alive enemies without a bullet in flight, caps the number
// of bullets in flight, and moves the nine enemy bullets down the screen.
module enemy_fire_scheduler #(
  parameter int FIRE_INTERVAL = 25_000_000,
  parameter int STEP_INTERVAL = 500_000,
  parameter int BULLET_STEP   = 2,
  parameter int BOTTOM_Y      = 475,
  parameter int MAX_ACTIVE    = 3
) (
  input  logic        clk,
  input  logic        Reset,
  input  logic        enable,
  input  logic [8:0]  alive,
  input  logic [9:0]  formation_x,
  input  logic [9:0]  formation_y,
  input  logic [8:0]  hit_clear,
  output logic [89:0] bullet_x,
  output logic [89:0] bullet_y,
  output logic [8:0]  bullet_active,
  output logic        fire_pulse,
  output logic [3:0]  grant_idx
);

  localparam int FIRE_W = (FIRE_INTERVAL > 1) ? $clog2(FIRE_INTERVAL) : 1;
  localparam int STEP_W = (STEP_INTERVAL > 1) ? $clog2(STEP_INTERVAL) : 1;

  logic [FIRE_W-1:0] fire_cnt;
  logic [STEP_W-1:0] step_cnt;
  logic              fire_attempt;
  logic              step_tick;

  logic [3:0]        rr_ptr;
  logic [8:0]        eligible;
  logic [3:0]        active_count;
  logic [4:0]        cand_sum;
  logic [3:0]        cand;
  logic              grant_found;
  logic [3:0]        grant_sel;
  logic              grant_valid;

  logic [9:0]        spawn_x [9];
  logic [9:0]        spawn_y [9];

  // Column offset of an enemy relative to enemy 0 (modulo-1024 arithmetic).
  function automatic logic [9:0] col_off(input int c);
    case (c)
      1:       col_off = 10'd999;
      2:       col_off = 10'd25;
      default: col_off = 10'd0;
    endcase
  endfunction

  // Row offset of an enemy above enemy 0; subtracted from formation_y.
  function automatic logic [9:0] row_off(input int r);
    case (r)
      1:       row_off = 10'd25;
      2:       row_off = 10'd50;
      default: row_off = 10'd0;
    endcase
  endfunction

  assign fire_attempt = enable && (fire_cnt == FIRE_W'(FIRE_INTERVAL - 1));
  assign step_tick    = enable && (step_cnt == STEP_W'(STEP_INTERVAL - 1));

  // Fire attempt timer: free-runs while the game is running, wraps on attempt.
  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      fire_cnt <= '0;
    end else if (enable) begin
      if (fire_attempt) fire_cnt <= '0;
      else              fire_cnt <= fire_cnt + FIRE_W'(1);
    end
  end

  // Bullet movement timer: same shape as the fire timer with its own period.
  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      step_cnt <= '0;
    end else if (enable) begin
      if (step_tick) step_cnt <= '0;
      else           step_cnt <= step_cnt + STEP_W'(1);
    end
  end

  // Muzzle position of every enemy: sprite origin plus the fixed gun offset.
  always_comb begin
    for (int i = 0; i < 9; i++) begin
      spawn_x[i] = formation_x + col_off(i % 3) + 10'd8;
      spawn_y[i] = formation_y - row_off(i / 3) + 10'd21;
    end
  end

  // Round-robin search from the enemy after the last shooter, gated by capacity.
  always_comb begin
    eligible     = alive & ~bullet_active;
    active_count = '0;
    cand_sum     = '0;
    cand         = '0;
    grant_found  = 1'b0;
    grant_sel    = '0;
    for (int i = 0; i < 9; i++) begin
      active_count = active_count + 4'(bullet_active[i]);
    end
    for (int k = 1; k <= 9; k++) begin
      cand_sum = {1'b0, rr_ptr} + 5'(k);
      cand     = (cand_sum >= 5'd9) ? 4'(cand_sum - 5'd9) : cand_sum[3:0];
      if (!grant_found && eligible[cand]) begin
        grant_found = 1'b1;
        grant_sel   = cand;
      end
    end
    grant_valid = fire_attempt && grant_found && (active_count < 4'(MAX_ACTIVE));
  end

  // Arbiter bookkeeping: remember the last shooter and strobe on each spawn.
  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      rr_ptr     <= 4'd8;
      grant_idx  <= '0;
      fire_pulse <= 1'b0;
    end else begin
      fire_pulse <= grant_valid;
      if (grant_valid) begin
        rr_ptr    <= grant_sel;
        grant_idx <= grant_sel;
      end
    end
  end

  // Per-bullet state: hits clear first, then movement/retire, idle slots may spawn.
  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      bullet_active <= '0;
      bullet_x      <= '0;
      bullet_y      <= '0;
    end else begin
      for (int i = 0; i < 9; i++) begin
        if (bullet_active[i]) begin
          if (hit_clear[i]) begin
            bullet_active[i] <= 1'b0;
          end else if (step_tick) begin
            if (({1'b0, bullet_y[10*i +: 10]} + 11'(BULLET_STEP)) > 11'(BOTTOM_Y)) begin
              bullet_active[i] <= 1'b0;
            end else begin
              bullet_y[10*i +: 10] <= bullet_y[10*i +: 10] + 10'(BULLET_STEP);
            end
          end
        end else if (grant_valid && (grant_sel == 4'(i))) begin
          bullet_active[i]     <= 1'b1;
          bullet_x[10*i +: 10] <= spawn_x[i];
          bullet_y[10*i +: 10] <= spawn_y[i];
        end
      end
    end
  end

endmodule
